// File: rtl/maku_uart_pkg.sv
// maku_uart_pkg
// Shared types and helpers for the UART transmit path.
//   parity_e      : frame parity selection (two encodings mean "no parity")
//   tx_state_e    : transmit FSM states
//   data_len()    : maps the 2-bit data-length field to a bit count (5..8)
//   parity_on()   : true when a parity bit is inserted into the frame
package maku_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'd0,
    PAR_EVEN  = 2'd1,
    PAR_ODD   = 2'd2,
    PAR_NONE2 = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_BREAK     = 3'd5,
    ST_BRK_GUARD = 3'd6
  } tx_state_e;

  // 100 MHz core clock / 115200 baud
  localparam int DEFAULT_BAUD_DIV = 868;

  function automatic logic [3:0] data_len(input logic [1:0] cfg_data_bits);
    return 4'd5 + {2'b00, cfg_data_bits};
  endfunction

  function automatic logic parity_on(input parity_e par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/maku_sync_fifo.sv
// maku_sync_fifo
// Single-clock FIFO. Read data is registered on the pop edge, so o_rdata
// holds the most recently popped entry until the next pop.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push       : write request; ignored while full (even if popping)
//   i_wdata      : write data
//   i_pop        : read request; ignored while empty
//   o_rdata      : last popped entry
//   o_full       : registered full flag
//   o_empty      : registered empty flag
//   o_count      : registered occupancy
module maku_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] r_rdata;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // Gating on the registered full flag means a full FIFO refuses a write
  // even when the same edge frees a slot.
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop  && !r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Storage has no reset; pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdata  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_rdata  <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/maku_uart_tx_engine.sv
// maku_uart_tx_engine
// UART transmitter with a write FIFO and runtime frame configuration.
//   i_clk, i_rst     : core clock, asynchronous active-high reset
//   i_cfg_div        : clocks per bit (0 and 1 behave as 2)
//   i_cfg_data_bits  : 0..3 -> 5..8 data bits
//   i_cfg_parity     : 0 none, 1 even, 2 odd, 3 none
//   i_cfg_stop2      : two stop bits when set
//   i_cfg_break      : hold the line low (honoured only between frames)
//   i_wr_valid/data  : byte write; accepted when o_wr_ready
//   o_wr_ready       : FIFO not full
//   o_tx             : serial line, idle high
//   o_busy           : FSM active or FIFO non-empty
//   o_fifo_count     : FIFO occupancy
//   o_tx_done        : one-cycle pulse in the last cycle of each frame
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | line high, waiting for break request or queued byte
// ST_START     | start bit (low)
// ST_DATA      | data bits, LSB first
// ST_PARITY    | parity bit
// ST_STOP      | 1 or 2 stop bits (high); chains into the next frame
// ST_BREAK     | line held low while break is requested
// ST_BRK_GUARD | one bit time high after a break, then idle
module maku_uart_tx_engine
  import maku_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int RESET_DIV  = DEFAULT_BAUD_DIV
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [DIV_W-1:0]                   i_cfg_div,
  input  logic [1:0]                         i_cfg_data_bits,
  input  logic [1:0]                         i_cfg_parity,
  input  logic                               i_cfg_stop2,
  input  logic                               i_cfg_break,
  input  logic                               i_wr_valid,
  input  logic [7:0]                         i_wr_data,
  output logic                               o_wr_ready,
  output logic                               o_tx,
  output logic                               o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
  output logic                               o_tx_done
);

  tx_state_e        r_state;
  tx_state_e        w_state_next;

  logic [DIV_W-1:0] r_baud;
  logic [DIV_W-1:0] w_baud_next;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_live;
  logic             w_bit_end;

  logic [3:0]       r_len;
  parity_e          r_parity;
  logic             r_stop2;
  logic             w_latch;

  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_next;
  logic             r_par;
  logic             w_par_next;
  logic             w_par_calc;
  logic [7:0]       w_len_mask;
  logic             w_last_data;
  logic             w_last_stop;

  logic             r_tx;
  logic             w_tx_next;
  logic             r_tx_done;
  logic             w_tx_done_next;

  logic             w_pop;
  logic [7:0]       w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  maku_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_wr_valid),
    .i_wdata (i_wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (o_fifo_count)
  );

  assign w_div_live  = (i_cfg_div < DIV_W'(2)) ? DIV_W'(2) : i_cfg_div;
  assign w_bit_end   = (r_baud == '0);

  // Parity is computed once, from the popped byte, on entry to DATA;
  // bits above the configured length are masked out.
  assign w_len_mask  = 8'hFF >> (4'd8 - r_len);
  assign w_par_calc  = (^(w_fifo_rdata & w_len_mask)) ^ (r_parity == PAR_ODD);
  assign w_last_data = ({1'b0, r_bit_idx} == (r_len - 4'd1));
  assign w_last_stop = r_stop2 ? (r_bit_idx == 3'd1) : 1'b1;

  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_par_next     = r_par;
    w_tx_next      = r_tx;
    w_tx_done_next = 1'b0;
    w_pop          = 1'b0;
    w_latch        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_next   = 1'b1;
        w_baud_next = '0;
        if (i_cfg_break) begin
          w_state_next = ST_BREAK;
          w_tx_next    = 1'b0;
        end else if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_latch      = 1'b1;
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
          w_baud_next  = w_div_live - DIV_W'(1);
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_tx_next      = w_fifo_rdata[0];
          w_shift_next   = {1'b0, w_fifo_rdata[7:1]};
          w_par_next     = w_par_calc;
          w_bit_idx_next = 3'd0;
          w_baud_next    = r_div - DIV_W'(1);
        end else begin
          w_baud_next = r_baud - DIV_W'(1);
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_next = r_div - DIV_W'(1);
          if (w_last_data) begin
            w_bit_idx_next = 3'd0;
            if (parity_on(r_parity)) begin
              w_state_next = ST_PARITY;
              w_tx_next    = r_par;
            end else begin
              w_state_next = ST_STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[0];
            w_shift_next   = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_baud_next = r_baud - DIV_W'(1);
        end
      end

      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next   = ST_STOP;
          w_tx_next      = 1'b1;
          w_bit_idx_next = 3'd0;
          w_baud_next    = r_div - DIV_W'(1);
        end else begin
          w_baud_next = r_baud - DIV_W'(1);
        end
      end

      ST_STOP: begin
        // div >= 2, so the counter passes through 1 exactly once per bit;
        // registering here puts the pulse on the final cycle.
        w_tx_done_next = w_last_stop && (r_baud == DIV_W'(1));
        if (w_bit_end) begin
          if (!w_last_stop) begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_baud_next    = r_div - DIV_W'(1);
          end else if (i_cfg_break) begin
            w_state_next = ST_BREAK;
            w_tx_next    = 1'b0;
            w_baud_next  = '0;
          end else if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_latch      = 1'b1;
            w_state_next = ST_START;
            w_tx_next    = 1'b0;
            w_baud_next  = w_div_live - DIV_W'(1);
          end else begin
            w_state_next = ST_IDLE;
            w_tx_next    = 1'b1;
            w_baud_next  = '0;
          end
        end else begin
          w_baud_next = r_baud - DIV_W'(1);
        end
      end

      ST_BREAK: begin
        w_tx_next = 1'b0;
        if (!i_cfg_break) begin
          w_state_next = ST_BRK_GUARD;
          w_tx_next    = 1'b1;
          w_baud_next  = r_div - DIV_W'(1);
        end
      end

      ST_BRK_GUARD: begin
        w_tx_next = 1'b1;
        if (w_bit_end) begin
          w_state_next = ST_IDLE;
          w_baud_next  = '0;
        end else begin
          w_baud_next = r_baud - DIV_W'(1);
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
        w_baud_next  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_tx_done <= 1'b0;
      r_div     <= DIV_W'(RESET_DIV);
      r_len     <= 4'd8;
      r_parity  <= PAR_NONE;
      r_stop2   <= 1'b0;
    end else begin
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_tx      <= w_tx_next;
      r_tx_done <= w_tx_done_next;
      // Frame format is frozen on entry to START; later config changes
      // only affect the following frame.
      if (w_latch) begin
        r_div    <= w_div_live;
        r_len    <= data_len(i_cfg_data_bits);
        r_parity <= parity_e'(i_cfg_parity);
        r_stop2  <= i_cfg_stop2;
      end
    end
  end

  assign o_tx       = r_tx;
  assign o_tx_done  = r_tx_done;
  assign o_wr_ready = !w_fifo_full;
  // Decoded purely from registered state; no input feeds this path.
  assign o_busy     = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_maku_uart_tx_engine.sv
module tb_maku_uart_tx_engine;

  localparam int DEPTH     = 16;
  localparam int DIV_W     = 16;
  localparam int RESET_DIV = 868;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIV_W-1:0]  cfg_div = 16'd4;
  logic [1:0]        cfg_data_bits = 2'd3;
  logic [1:0]        cfg_parity = 2'd0;
  logic              cfg_stop2 = 1'b0;
  logic              cfg_break = 1'b0;
  logic              wr_valid = 1'b0;
  logic [7:0]        wr_data = 8'd0;
  logic              o_wr_ready;
  logic              o_tx;
  logic              o_busy;
  logic [4:0]        o_fifo_count;
  logic              o_tx_done;

  always #5 clk = ~clk;

  maku_uart_tx_engine #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DIV_W),
    .RESET_DIV  (RESET_DIV)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cfg_div       (cfg_div),
    .i_cfg_data_bits (cfg_data_bits),
    .i_cfg_parity    (cfg_parity),
    .i_cfg_stop2     (cfg_stop2),
    .i_cfg_break     (cfg_break),
    .i_wr_valid      (wr_valid),
    .i_wr_data       (wr_data),
    .o_wr_ready      (o_wr_ready),
    .o_tx            (o_tx),
    .o_busy          (o_busy),
    .o_fifo_count    (o_fifo_count),
    .o_tx_done       (o_tx_done)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The line is modelled as a queue of per-cycle levels. Whenever the queue
  // runs dry the model decides what the line does next (break, next frame,
  // or idle) and appends a whole segment.
  bit         m_tx_q[$];
  bit         m_done_q[$];
  bit         m_act_q[$];
  logic [7:0] m_fifo[$];
  bit         m_in_break;
  int         m_lat_div;
  logic       exp_tx, exp_done, exp_busy, exp_ready;
  int         exp_count;

  task automatic m_push(input bit t, input bit d, input bit a);
    m_tx_q.push_back(t);
    m_done_q.push_back(d);
    m_act_q.push_back(a);
  endtask

  task automatic m_frame(input logic [7:0] d);
    int div, n;
    bit p;
    bit bits[$];
    div = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
    m_lat_div = div;
    n = 5 + int'(cfg_data_bits);
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (cfg_parity == 2'd1) bits.push_back(p);
    else if (cfg_parity == 2'd2) bits.push_back(!p);
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < div; c++)
        m_push(bits[b], (b == bits.size() - 1) && (c == div - 1), 1'b1);
  endtask

  always @(posedge clk or posedge rst) begin : model
    bit acc;
    bit act;
    if (rst) begin
      m_tx_q.delete();
      m_done_q.delete();
      m_act_q.delete();
      m_fifo.delete();
      m_in_break = 1'b0;
      m_lat_div  = RESET_DIV;
      exp_tx = 1'b1; exp_done = 1'b0; exp_busy = 1'b0; exp_ready = 1'b1;
      exp_count = 0;
    end else begin
      acc = wr_valid && (m_fifo.size() < DEPTH);
      if (m_tx_q.size() == 0) begin
        if (m_in_break) begin
          if (!cfg_break) begin
            m_in_break = 1'b0;
            for (int i = 0; i < m_lat_div; i++) m_push(1'b1, 1'b0, 1'b1);
            m_push(1'b1, 1'b0, 1'b0);
          end else begin
            m_push(1'b0, 1'b0, 1'b1);
          end
        end else if (cfg_break) begin
          m_in_break = 1'b1;
          m_push(1'b0, 1'b0, 1'b1);
        end else if (m_fifo.size() > 0) begin
          m_frame(m_fifo.pop_front());
        end else begin
          m_push(1'b1, 1'b0, 1'b0);
        end
      end
      exp_tx   = m_tx_q.pop_front();
      exp_done = m_done_q.pop_front();
      act      = m_act_q.pop_front();
      if (acc) m_fifo.push_back(wr_data);
      exp_count = m_fifo.size();
      exp_ready = (m_fifo.size() < DEPTH);
      exp_busy  = act || (m_fifo.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("tx", o_tx, exp_tx);
      chk("tx_done", o_tx_done, exp_done);
      chk("busy", o_busy, exp_busy);
      chk("wr_ready", o_wr_ready, exp_ready);
      chk("fifo_count", o_fifo_count, exp_count);
    end
  end

  // ---------------- stimulus ----------------
  logic s_tx   [1:64];
  logic s_done [1:64];
  logic s_busy [1:64];

  task automatic write_byte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      s_tx[k]   = o_tx;
      s_done[k] = o_tx_done;
      s_busy[k] = o_busy;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, o_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    logic [7:0] pat8;
    int cnt, zeros, n;

    repeat (3) @(negedge clk);
    chk("rst_tx", o_tx, 1'b1);
    chk("rst_count", o_fifo_count, 0);
    chk("rst_ready", o_wr_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_tx_done, 1'b0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, div 4, 0xA5
    write_byte(8'hA5);
    capture(41);
    pat = 10'b1101001010;
    for (int b = 0; b < 10; b++) chk($sformatf("a5_bit%0d", b), s_tx[4*b+2], pat[b]);
    chk("a5_first", s_tx[1], 1'b0);
    chk("a5_done39", s_done[39], 1'b0);
    chk("a5_done40", s_done[40], 1'b1);
    chk("a5_busy40", s_busy[40], 1'b1);
    chk("a5_busy41", s_busy[41], 1'b0);

    // 7 data bits, even then odd parity, 0x87
    cfg_data_bits = 2'd2;
    cfg_parity    = 2'd1;
    write_byte(8'h87);
    capture(41);
    pat = 10'b1100001110;
    for (int b = 0; b < 10; b++) chk($sformatf("e87_bit%0d", b), s_tx[4*b+2], pat[b]);
    chk("e87_done40", s_done[40], 1'b1);
    cfg_parity = 2'd2;
    write_byte(8'h87);
    capture(41);
    pat = 10'b1000001110;
    for (int b = 0; b < 10; b++) chk($sformatf("o87_bit%0d", b), s_tx[4*b+2], pat[b]);

    // 5N2, div 3, 0xFF
    cfg_div = 16'd3; cfg_data_bits = 2'd0; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
    write_byte(8'hFF);
    capture(25);
    pat8 = 8'b11111110;
    for (int b = 0; b < 8; b++) chk($sformatf("n52_bit%0d", b), s_tx[3*b+2], pat8[b]);
    chk("n52_done21", s_done[21], 1'b0);
    chk("n52_done24", s_done[24], 1'b1);
    chk("n52_busy25", s_busy[25], 1'b0);

    // break during a frame
    cfg_div = 16'd4; cfg_data_bits = 2'd3; cfg_stop2 = 1'b0;
    write_byte(8'($urandom));
    repeat (12) @(negedge clk);
    cfg_break = 1'b1;
    n = 0;
    while (!o_tx_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("brk_frame_done", o_tx_done, 1'b1);
    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_tx == 1'b0) zeros++;
    end
    chk("brk_low_cycles", zeros, 100);
    cfg_break = 1'b0;
    capture(5);
    chk("guard_tx1", s_tx[1], 1'b1);
    chk("guard_tx4", s_tx[4], 1'b1);
    chk("guard_busy4", s_busy[4], 1'b1);
    chk("guard_busy5", s_busy[5], 1'b0);

    // fill the FIFO behind a break, then release
    cfg_break = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      if (i == 0) chk("fill_ready0", o_wr_ready, 1'b1);
      if (i == 16) begin
        chk("fill_ready16", o_wr_ready, 1'b0);
        chk("fill_count16", o_fifo_count, 16);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("fill_count_after", o_fifo_count, 16);
    cfg_break = 1'b0;
    cnt = 0;
    n = 0;
    while ((o_busy || n < 2) && n < 1200) begin
      @(negedge clk);
      if (o_tx_done) cnt++;
      n++;
    end
    chk("fill_drained", o_busy, 1'b0);
    chk("fill_done_pulses", cnt, 16);

    // reset mid-DATA with 3 bytes queued
    cfg_div = 16'd8;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_count", o_fifo_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", o_tx, 1'b1);
    chk("arst_count", o_fifo_count, 0);
    chk("arst_ready", o_wr_ready, 1'b1);
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_done", o_tx_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    zeros = 0;
    repeat (200) begin
      @(negedge clk);
      if (o_tx_done) cnt++;
      if (!o_tx) zeros++;
    end
    chk("post_rst_done", cnt, 0);
    chk("post_rst_low", zeros, 0);

    // randomized traffic with config changes mid-flight
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_div       = 16'($urandom_range(0, 6));
        cfg_data_bits = 2'($urandom_range(0, 3));
        cfg_parity    = 2'($urandom_range(0, 3));
        cfg_stop2     = 1'($urandom_range(0, 1));
      end
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = 8'($urandom);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_idle(3000, "rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maku_uart_tx_engine.md
Name: maku_uart_tx_engine

Overview:
- Parametrised, synthesizable UART transmitter with a write FIFO. It replaces the hand-timed bit-banged serial stimulus used at system level.
- Frame format is runtime-configurable: baud divisor, 5–8 data bits, parity, 1 or 2 stop bits, and line break generation.
- Sits between the core's peripheral bus and the uart_tx pad inside maku_system_top. The system bench also uses it as a reusable serial stimulus source for the receiver path.

Parameters:
- FIFO_DEPTH, 16, write FIFO entries; power of two, ≥2.
- DIV_W, 16, width of baud divisor.
- RESET_DIV, 868, divisor used until first cfg write (100 MHz / 115200).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_div  in  DIV_W  clocks per bit; values 0 and 1 are treated as 2.
- cfg_data_bits  in  2  data length: 0→5, 1→6, 2→7, 3→8 bits.
- cfg_parity  in  2  0 none, 1 even, 2 odd, 3 none.
- cfg_stop2  in  1  1 selects two stop bits.
- cfg_break  in  1  request a line break.
- wr_valid  in  1  write request.
- wr_data  in  8  byte to send; bits above the data length are ignored.
- wr_ready  out  1  equals !fifo_full.
- tx  out  1  serial line; idle high.
- busy  out  1  high in any state other than IDLE, or when the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (async, any time, including mid-frame): tx=1 immediately, FIFO emptied, fifo_count=0, wr_ready=1, busy=0, tx_done=0, FSM→IDLE, baud counter=0. All outputs are registered.
- Write handshake: accepted on the rising edge where wr_valid && wr_ready.
  - Writing when full is never accepted, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves fifo_count unchanged.
- Config latch: cfg_div, cfg_data_bits, cfg_parity and cfg_stop2 are latched on entry to START. Changes take effect only at the next frame.
- Baud counter: loaded with div-1 at each bit start and decremented each cycle. The bit ends when the counter is 0, so each bit lasts exactly div cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK, BRK_GUARD.
  - IDLE: tx=1.
    - If cfg_break is high → BREAK; break takes priority over the FIFO.
    - Else if the FIFO is non-empty: pop, load the shift register, →START.
  - START: tx=0 for one bit time → DATA.
  - DATA: LSB first, N bits.
    - →PARITY if parity is enabled, else →STOP.
  - PARITY: bit = XOR of the N data bits (even), or its inverse (odd).
  - STOP: tx=1 for 1 or 2 bit times.
    - tx_done pulses in the last cycle of STOP.
    - If cfg_break is high → BREAK.
    - Else if the FIFO is non-empty: pop and →START on the next edge. There are no idle cycles between back-to-back frames.
    - Else →IDLE.
  - BREAK: tx=0 while cfg_break stays high.
    - On deassert → BRK_GUARD: tx=1 for one latched bit time → IDLE.
- Break asserted mid-frame does not corrupt the frame. It is honoured at the STOP exit.
- Latency: write accepted at edge E0 with FSM idle and FIFO empty → pop at E1, tx falls after E1.
- Frame length: (1 + N + P + S) × div cycles, where N = data bits, P = 1 if parity enabled else 0, S = stop bits.

Decomposition:
- Package maku_uart_pkg holds:
  - typedef enum parity_e {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE2};
  - typedef enum tx_state_e for the FSM states;
  - function data_len(cfg_data_bits);
  - constant DEFAULT_BAUD_DIV = 868.
- Sub-module maku_sync_fifo (parameters WIDTH, DEPTH) provides push/pop, count, full and empty, with read data registered at pop. The engine contains the FSM, baud counter and shift register.

Test Plan:
1. div=4, 8N1, write 0xA5 → tx after E1 is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses at cycle 40 of the frame; busy falls the next cycle.
2. div=4, 7 data bits, even parity, write 0x87 → data 1,1,1,0,0,0,0, parity bit=1, then stop; total frame 40 cycles. With odd parity the parity bit=0.
3. With the line stalled by cfg_break, write 17 bytes in consecutive cycles → first 16 accepted, wr_ready=0 on the 17th, fifo_count=16. Release the break → BRK_GUARD, then 16 frames back-to-back with no idle-high gap beyond stop bits, 16 tx_done pulses.
4. cfg_data_bits=0, 5N2, write 0xFF → five 1 data bits; stop lasts 2×div cycles; bits 7:5 are ignored.
5. Assert cfg_break for 100 cycles during a frame → current frame completes intact, then tx=0 for 100 cycles, then tx=1 for one bit time, then IDLE.
6. Assert rst mid-DATA with 3 bytes queued → tx=1 asynchronously; fifo_count=0; after release no frame is sent and tx_done does not pulse.
